// File: rtl/memory_arbiter.sv
// Single-ported RAM responder for the instruction and data request ports.
// Data accesses win, but iREN is forced through after DSTREAK data grants.
module memory_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DSTREAK = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ramready
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] IACC = 2'd1;
    localparam logic [1:0] DRD  = 2'd2;
    localparam logic [1:0] DWR  = 2'd3;

    localparam int SW = $clog2(DSTREAK + 1);
    localparam logic [SW-1:0] SMAX = SW'(DSTREAK);

    logic [1:0]        state, state_n;
    logic [SW-1:0]     streak, streak_n;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              dreq, starve, live;

    assign dreq   = dREN | dWEN;
    assign starve = iREN && dreq && (streak == SMAX);

    // Requester still holding the request that owns the current access
    always_comb begin
        live = 1'b0;
        unique case (state)
            IACC:    live = iREN;
            DRD:     live = dREN;
            DWR:     live = dWEN;
            default: live = 1'b0;
        endcase
    end

    always_comb begin
        state_n  = state;
        streak_n = streak;
        if (state == IDLE) begin
            if (starve) begin
                state_n  = IACC;
                streak_n = '0;
            end else if (dreq) begin
                state_n = dWEN ? DWR : DRD;
                if (!iREN)
                    streak_n = '0;
                else if (streak != SMAX)
                    streak_n = streak + SW'(1);
            end else if (iREN) begin
                state_n  = IACC;
                streak_n = '0;
            end else begin
                streak_n = '0;
            end
        end else if (!live || ramready) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            streak <= '0;
            addr   <= '0;
            data   <= '0;
        end else begin
            state  <= state_n;
            streak <= streak_n;
            if (state == IDLE) begin
                if (state_n == IACC)
                    addr <= iaddr;
                else if (state_n == DRD)
                    addr <= daddr;
                else if (state_n == DWR) begin
                    addr <= daddr;
                    data <= dstore;
                end
            end
        end
    end

    // Strobes and wait pulses also qualify on the live request so aborts drop same cycle
    assign ramREN   = ((state == IACC) && iREN) || ((state == DRD) && dREN);
    assign ramWEN   = (state == DWR) && dWEN;
    assign iwait    = !((state == IACC) && iREN && ramready);
    assign dwait    = !((((state == DRD) && dREN) ||
                         ((state == DWR) && dWEN)) && ramready);
    assign ramaddr  = addr;
    assign ramstore = data;
    assign iload    = ramload;
    assign dload    = ramload;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: requester tasks push expected
// completions, a negedge monitor pops and checks every wait pulse.
module tb_memory_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic        iwait, dwait, ramREN, ramWEN, ramready;
    logic [31:0] iload, dload, ramaddr, ramstore, ramload;

    int tests   = 0;
    int fails   = 0;
    int lat     = 1;
    int rcnt    = 0;
    int strobes = 0;

    typedef struct {
        bit          is_d;
        bit          chk;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    memory_arbiter #(.ADDR_W(32), .DATA_W(32), .DSTREAK(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramready(ramready)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h40:  return 32'h2000FFFF;
            32'h80:  return 32'h12345678;
            32'h100: return 32'hCAFE0100;
            default: return 32'hBAD00000 | (a & 32'hFFFF);
        endcase
    endfunction

    // RAM model: ready on the lat-th consecutive strobe cycle
    assign ramload  = mem(ramaddr);
    assign ramready = (ramREN | ramWEN) && (rcnt >= lat - 1);

    always @(posedge CLK)
        rcnt <= ((ramREN | ramWEN) && !ramready) ? rcnt + 1 : 0;

    always @(negedge CLK)
        if (ramREN | ramWEN) strobes <= strobes + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void push(input bit is_d, input bit chk,
                                 input logic [31:0] d);
        exp_t e;
        e.is_d = is_d;
        e.chk  = chk;
        e.data = d;
        sb.push_back(e);
    endfunction

    always @(negedge CLK) begin
        if (nRST && (!iwait || !dwait)) begin
            if (!iwait && !dwait) begin
                tests++;
                fails++;
                $display("FAIL both_wait_low: got iwait=%b dwait=%b expected one", iwait, dwait);
            end else if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: got iwait=%b dwait=%b expected none", iwait, dwait);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_port", {31'b0, !dwait}, {31'b0, e.is_d});
                if (e.chk)
                    check("sb_data", !dwait ? dload : iload, e.data);
            end
        end
    end

    task automatic i_txn(input logic [31:0] a, input bit chk);
        int n;
        bit first;
        n     = 0;
        first = 1'b1;
        iREN  = 1'b1;
        iaddr = a;
        while (n < 60) begin
            @(negedge CLK);
            n++;
            if (chk && ramREN) begin
                check("i_ramaddr", ramaddr, a);
                check("i_ramWEN", {31'b0, ramWEN}, 32'd0);
                if (first) iaddr = a ^ 32'hFFF0;
                first = 1'b0;
            end
            if (!iwait) break;
        end
        if (iwait) check("i_timeout", {31'b0, iwait}, 32'd0);
        @(posedge CLK);
        #1;
        iREN = 1'b0;
    endtask

    task automatic d_txn(input logic [31:0] a, input bit wr, input bit rd,
                         input logic [31:0] st, input bit chk);
        int n;
        bit first;
        n      = 0;
        first  = 1'b1;
        dWEN   = wr;
        dREN   = rd;
        daddr  = a;
        dstore = st;
        while (n < 60) begin
            @(negedge CLK);
            n++;
            if (chk && (ramREN | ramWEN)) begin
                check("d_ramaddr", ramaddr, a);
                check("d_ramWEN", {31'b0, ramWEN}, {31'b0, wr});
                check("d_ramREN", {31'b0, ramREN}, {31'b0, !wr});
                if (wr) check("d_ramstore", ramstore, st);
                if (first) begin
                    daddr  = a ^ 32'hFFF0;
                    dstore = ~st;
                end
                first = 1'b0;
            end
            if (!dwait) break;
        end
        if (dwait) check("d_timeout", {31'b0, dwait}, 32'd0);
        @(posedge CLK);
        #1;
        dWEN = 1'b0;
        dREN = 1'b0;
    endtask

    initial begin
        int s0, n;
        nRST   = 1'b0;
        iREN   = 1'b1;
        dREN   = 1'b1;
        dWEN   = 1'b1;
        iaddr  = 32'h40;
        daddr  = 32'h80;
        dstore = 32'h55;
        #12;
        check("rst_ramREN", {31'b0, ramREN}, 32'd0);
        check("rst_ramWEN", {31'b0, ramWEN}, 32'd0);
        check("rst_iwait", {31'b0, iwait}, 32'd1);
        check("rst_dwait", {31'b0, dwait}, 32'd1);
        check("rst_ramaddr", ramaddr, 32'd0);
        check("rst_ramstore", ramstore, 32'd0);
        iREN = 1'b0;
        dREN = 1'b0;
        dWEN = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        lat = 3;
        s0  = strobes;
        push(1'b0, 1'b1, 32'h2000FFFF);
        i_txn(32'h40, 1'b1);
        check("i_strobe_cycles", strobes - s0, 32'd3);

        lat = 1;
        s0  = strobes;
        push(1'b0, 1'b1, 32'h2000FFFF);
        i_txn(32'h40, 1'b1);
        check("min_latency", strobes - s0, 32'd1);

        push(1'b1, 1'b1, 32'h12345678);
        push(1'b0, 1'b1, 32'h2000FFFF);
        fork
            i_txn(32'h40, 1'b0);
            d_txn(32'h80, 1'b0, 1'b1, 32'h0, 1'b0);
        join

        lat = 2;
        push(1'b1, 1'b0, 32'h0);
        d_txn(32'h100, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1);

        lat = 1;
        for (int k = 0; k < 4; k++) push(1'b1, 1'b1, 32'h12345678);
        push(1'b0, 1'b1, 32'h2000FFFF);
        for (int k = 0; k < 2; k++) push(1'b1, 1'b1, 32'h12345678);
        fork
            i_txn(32'h40, 1'b0);
            for (int k = 0; k < 6; k++) d_txn(32'h80, 1'b0, 1'b1, 32'h0, 1'b0);
        join

        lat   = 5;
        dREN  = 1'b1;
        daddr = 32'h80;
        n     = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!ramREN && n < 20);
        check("abort_strobe_seen", {31'b0, ramREN}, 32'd1);
        @(posedge CLK);
        #1;
        dREN = 1'b0;
        #1;
        check("abort_ramREN", {31'b0, ramREN}, 32'd0);
        check("abort_dwait", {31'b0, dwait}, 32'd1);
        @(negedge CLK);
        check("abort_ramREN_hold", {31'b0, ramREN}, 32'd0);
        repeat (2) @(posedge CLK);
        #1;

        iREN  = 1'b1;
        iaddr = 32'h40;
        n     = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!ramREN && n < 20);
        check("rst_mid_strobe_seen", {31'b0, ramREN}, 32'd1);
        @(posedge CLK);
        #1;
        nRST = 1'b0;
        #1;
        check("rst_mid_ramREN", {31'b0, ramREN}, 32'd0);
        check("rst_mid_iwait", {31'b0, iwait}, 32'd1);
        iREN = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;

        lat = 1;
        push(1'b0, 1'b1, 32'h2000FFFF);
        i_txn(32'h40, 1'b1);
        repeat (3) @(posedge CLK);
        check("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
